sram_arb_ctrl: RTL and testbench
================================

Name: sram_arb_ctrl

Overview:
- Sequencing controller and two-port arbiter for the 16-bit asynchronous SRAM pin driver (mem_address/mem_wren/mem_rden/data_in/data_out side).
- Accepts 32-bit word requests from two masters (m0, m1), e.g. core data port and DMA.
- Splits each request into two 16-bit SRAM accesses with programmable wait states.
- Returns one response pulse per request to the issuing master.

Parameters:
- AW, 20, SRAM halfword address width; master word address is AW-1 bits.
- WS, 1, extra wait cycles per access strobe; legal range 0..15; strobe length is WS+1 cycles.

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous reset, active-high
- m0_valid  input  1  master 0 request valid
- m0_ready  output  1  master 0 request accepted this cycle
- m0_we  input  1  1 = write, 0 = read
- m0_addr  input  AW-1  32-bit word address
- m0_wdata  input  32  write data
- m0_rsp_valid  output  1  one-cycle completion pulse
- m0_rdata  output  32  read data, valid with m0_rsp_valid
- m1_valid, m1_ready, m1_we, m1_addr, m1_wdata, m1_rsp_valid, m1_rdata: same as m0, for master 1
- mem_address  output  AW  halfword address to SRAM driver
- mem_wren  output  1  write strobe, active-high
- mem_rden  output  1  read strobe, active-high
- data_in  output  16  write data to SRAM driver
- data_out  input  16  read data from SRAM driver

Behaviour:
- Fixed decision: one clock, CLK; reset is synchronous and active-high, RST.
- All mem_*, data_in, rsp_valid and rdata outputs are registered.
- Reset values: all outputs 0; state IDLE; last_grant = 1, so m0 wins the first tie.
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_PULSE, RESP.
- Acceptance:
  - mX_ready is combinational: (state == IDLE) & mX_valid & (grant == X).
  - Only one master is accepted per cycle.
  - On accept, latch id, we, addr and wdata; set half = 0.
- Halfword mapping:
  - mem_address = {addr, half}.
  - half 0 carries bits 15:0 and is always performed first; half 1 carries bits 31:16.
- Read sequence:
  - R_PULSE for WS+1 cycles with mem_rden = 1 and mem_address stable.
  - data_out is captured at the clock edge ending the last R_PULSE cycle.
  - Then half 1 runs immediately, with no idle cycle between halves.
  - Then RESP.
- Write sequence, per half:
  - W_SETUP: 1 cycle, address and data driven, mem_wren = 0.
  - W_PULSE: WS+1 cycles, mem_wren = 1.
  - W_HOLD: 1 cycle, mem_wren = 0, address and data still stable.
  - Then half 1, then RESP.
- RESP:
  - One cycle with mX_rsp_valid = 1 for the latched id.
  - mX_rdata holds the assembled word on reads and is unchanged on writes.
  - Next state is IDLE.
- Latency from the accept cycle (cycle 0):
  - Read response at cycle 2*WS+3.
  - Write response at cycle 2*WS+7.
  - Next accept is earliest at response cycle + 1.
- Strobe rules:
  - mem_wren and mem_rden are never both 1.
  - Both are 0 in IDLE and RESP.
  - data_in and mem_address never change while a strobe is high.
- Arbitration with both masters valid in IDLE: grant goes to the master other than last_grant; last_grant updates on accept.
- A master may hold valid high across its own response; it is re-accepted only via arbitration in IDLE.
- A master whose valid drops before acceptance is simply not served; there is no queueing.
- WS counter: 4 bits, loaded with WS on strobe entry, decremented each cycle; it never wraps.
- Reset mid-operation:
  - State returns to IDLE and mem_wren/mem_rden go to 0 at the reset edge.
  - No rsp_valid is issued for the aborted request.
  - A partial write may leave half 0 written; this is acceptable.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, m0 always wins a tie; last_grant is removed.

Test Plan:
- WS=1, m0 read of addr 0x00010 with SRAM model holding 0x0020=0xBEEF and 0x0021=0xDEAD:
  - mem_rden is high during cycles 1-2 at address 0x00020, then cycles 3-4 at 0x00021.
  - m0_rsp_valid fires at cycle 5 with m0_rdata = 0xDEADBEEF.
- WS=1, m1 write of 0x12345678 to addr 0x3:
  - mem_wren is high during cycles 2-3 (address 0x6, data_in 0x5678) and cycles 6-7 (address 0x7, data_in 0x1234).
  - m1_rsp_valid fires at cycle 9.
- Both masters valid continuously with reads, RR enabled: grants alternate m0, m1, m0, m1 over 4 requests; each response goes to the correct id.
- Same traffic with SRAM_ARB_RR_EN undefined: m0 is granted all 4 times; m1_ready stays 0.
- WS=0, back-to-back reads: the read response is at cycle 3 and the next accept at cycle 4.
- RST asserted in the W_PULSE cycle of half 0:
  - mem_wren = 0 on the next cycle and no rsp_valid is issued.
  - The controller accepts a new request on the cycle after RST deasserts.

Source files
------------

// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: two-master arbiter splitting 32-bit requests into two wait-stated 16-bit async SRAM accesses.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise m0 wins every tie.
module sram_arb_ctrl #(
    parameter int AW = 20,
    parameter int WS = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          m0_valid,
    output logic          m0_ready,
    input  logic          m0_we,
    input  logic [AW-2:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_rsp_valid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_valid,
    output logic          m1_ready,
    input  logic          m1_we,
    input  logic [AW-2:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_rsp_valid,
    output logic [31:0]   m1_rdata,
    output logic [AW-1:0] mem_address,
    output logic          mem_wren,
    output logic          mem_rden,
    output logic [15:0]   data_in,
    input  logic [15:0]   data_out
);
    typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_PULSE, RESP} state_t;
    localparam logic [3:0] WS4 = 4'(WS);
    state_t state_q, state_d;
    logic id_q, id_d, we_q, we_d, half_q, half_d;
    logic [AW-2:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [3:0] cnt_q, cnt_d;
    logic [15:0] lo_q, lo_d, data_in_q, data_in_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic mem_wren_q, mem_wren_d, mem_rden_q, mem_rden_d;
    logic rsp0_q, rsp0_d, rsp1_q, rsp1_d;
    logic g1, accept, last_cnt;
`ifdef SRAM_ARB_RR_EN
    logic last_q;
    assign g1 = m1_valid & (~m0_valid | ~last_q);
    always_ff @(posedge CLK) last_q <= RST ? 1'b1 : (accept ? g1 : last_q);
`else
    assign g1 = m1_valid & ~m0_valid;
`endif
    assign m0_ready = (state_q == IDLE) & m0_valid & ~g1;
    assign m1_ready = (state_q == IDLE) & g1;
    assign accept = m0_ready | m1_ready;
    assign last_cnt = cnt_q == 4'd0;
    assign mem_address = mem_address_q;
    assign mem_wren = mem_wren_q;
    assign mem_rden = mem_rden_q;
    assign data_in = data_in_q;
    assign m0_rsp_valid = rsp0_q;
    assign m1_rsp_valid = rsp1_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            id_q <= 1'b0;
            we_q <= 1'b0;
            half_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            cnt_q <= '0;
            lo_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            mem_address_q <= '0;
            mem_wren_q <= 1'b0;
            mem_rden_q <= 1'b0;
            data_in_q <= '0;
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q <= id_d;
            we_q <= we_d;
            half_q <= half_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            cnt_q <= cnt_d;
            lo_q <= lo_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            mem_address_q <= mem_address_d;
            mem_wren_q <= mem_wren_d;
            mem_rden_q <= mem_rden_d;
            data_in_q <= data_in_d;
            rsp0_q <= rsp0_d;
            rsp1_q <= rsp1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d = id_q;
        we_d = we_q;
        half_d = half_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        cnt_d = last_cnt ? 4'd0 : cnt_q - 4'd1;
        lo_d = lo_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: if (accept) begin
                id_d = m1_ready;
                we_d = m1_ready ? m1_we : m0_we;
                addr_d = m1_ready ? m1_addr : m0_addr;
                wdata_d = m1_ready ? m1_wdata : m0_wdata;
                half_d = 1'b0;
                cnt_d = WS4;
                state_d = we_d ? W_SETUP : R_PULSE;
            end
            W_SETUP: begin
                cnt_d = WS4;
                state_d = W_PULSE;
            end
            W_PULSE: state_d = last_cnt ? W_HOLD : W_PULSE;
            W_HOLD: begin
                half_d = 1'b1;
                state_d = half_q ? RESP : W_SETUP;
            end
            // Half 1 reloads the strobe counter directly so the two read halves run back to back.
            R_PULSE: if (last_cnt) begin
                cnt_d = WS4;
                half_d = 1'b1;
                lo_d = data_out;
                rdata0_d = (half_q & ~id_q) ? {data_out, lo_q} : rdata0_q;
                rdata1_d = (half_q & id_q) ? {data_out, lo_q} : rdata1_q;
                state_d = half_q ? RESP : R_PULSE;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_wren_d = state_d == W_PULSE;
        mem_rden_d = state_d == R_PULSE;
        mem_address_d = {addr_d, half_d};
        data_in_d = half_d ? wdata_d[31:16] : wdata_d[15:0];
        rsp0_d = (state_d == RESP) & ~id_d;
        rsp1_d = (state_d == RESP) & id_d;
    end
endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb_sram_arb_ctrl: directed vector bench for sram_arb_ctrl with a 64-halfword SRAM model.
module tb_sram_arb_ctrl;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef struct {int id; bit we; logic [18:0] a; logic [31:0] wd; logic [31:0] rd; int lat;} vec_t;
    typedef struct packed {logic [7:0] c; logic w; logic [19:0] a; logic [15:0] d;} ent_t;

    logic clk = 1'b0;
    logic RST;
    logic m0_valid, m0_we, m0_ready, m0_rsp_valid, m1_valid, m1_we, m1_ready, m1_rsp_valid;
    logic [18:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [19:0] mem_address;
    logic mem_wren, mem_rden;
    logic [15:0] data_in, data_out;
    logic b_m0_valid, b_m0_we, b_m0_ready, b_m0_rsp_valid, b_m1_ready, b_m1_rsp_valid;
    logic [18:0] b_m0_addr;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic [19:0] b_mem_address;
    logic b_mem_wren, b_mem_rden;
    logic [15:0] b_data_in, b_data_out;
    logic [15:0] sram [64];
    logic ld_en;
    logic [5:0] ld_a;
    logic [15:0] ld_d;
    int passed = 0, total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (ld_en) sram[ld_a] <= ld_d;
        else if (mem_wren) sram[mem_address[5:0]] <= data_in;
    end
    assign data_out = sram[mem_address[5:0]];
    assign b_data_out = sram[b_mem_address[5:0]];

    sram_arb_ctrl #(.AW(20), .WS(1)) dut (
        .CLK(clk), .RST(RST),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_rden(mem_rden),
        .data_in(data_in), .data_out(data_out)
    );

    sram_arb_ctrl #(.AW(20), .WS(0)) dut_b (
        .CLK(clk), .RST(RST),
        .m0_valid(b_m0_valid), .m0_ready(b_m0_ready), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(32'h0),
        .m0_rsp_valid(b_m0_rsp_valid), .m0_rdata(b_m0_rdata),
        .m1_valid(1'b0), .m1_ready(b_m1_ready), .m1_we(1'b0), .m1_addr(19'h0), .m1_wdata(32'h0),
        .m1_rsp_valid(b_m1_rsp_valid), .m1_rdata(b_m1_rdata),
        .mem_address(b_mem_address), .mem_wren(b_mem_wren), .mem_rden(b_mem_rden),
        .data_in(b_data_in), .data_out(b_data_out)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    initial begin
        vec_t vt[6];
        ent_t lg[$];
        ent_t ex[$];
        logic [31:0] last_rd[2];
        logic [31:0] rdv;
        logic [31:0] rdq[4];
        logic gq[4];
        logic rq[4];
        logic pw, h;
        logic [19:0] pa;
        logic [15:0] pd;
        int lat, rid, viol, n0, nrd, rc, nxt, ng, nr, both, m1seen, cyc;
        vt[0] = '{0, 1'b0, 19'h10, 32'h0,        32'hDEADBEEF, 5};
        vt[1] = '{1, 1'b1, 19'h3,  32'h12345678, 32'h0,        9};
        vt[2] = '{1, 1'b0, 19'h3,  32'h0,        32'h12345678, 5};
        vt[3] = '{0, 1'b1, 19'h8,  32'hA5A50F0F, 32'h0,        9};
        vt[4] = '{0, 1'b0, 19'h8,  32'h0,        32'hA5A50F0F, 5};
        vt[5] = '{1, 1'b0, 19'h10, 32'h0,        32'hDEADBEEF, 5};
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        RST = 1'b1;
        {m0_valid, m0_we, m1_valid, m1_we, b_m0_valid, b_m0_we} = '0;
        m0_addr = '0; m1_addr = '0; b_m0_addr = '0; m0_wdata = '0; m1_wdata = '0;
        ld_en = 1'b1; ld_a = 6'h20; ld_d = 16'hBEEF;
        @(posedge clk); #1;
        ld_a = 6'h21; ld_d = 16'hDEAD;
        @(posedge clk); #1;
        ld_en = 1'b0;
        @(posedge clk); #1;
        RST = 1'b0;
        #1;
        chk("rst_mem_address", mem_address, 0);
        chk("rst_strobes", {mem_wren, mem_rden}, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_rsp", {m0_rsp_valid, m1_rsp_valid, m0_ready, m1_ready}, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);

        for (int i = 0; i < 6; i++) begin
            lat = -1; rid = -1; rdv = '0; viol = 0; pw = 1'b0; pa = '0; pd = '0;
            lg.delete(); ex.delete();
            if (vt[i].id == 0) begin
                m0_valid = 1'b1; m0_we = vt[i].we; m0_addr = vt[i].a; m0_wdata = vt[i].wd;
            end else begin
                m1_valid = 1'b1; m1_we = vt[i].we; m1_addr = vt[i].a; m1_wdata = vt[i].wd;
            end
            #1 chk($sformatf("v%0d_ready", i), (vt[i].id == 1) ? m1_ready : m0_ready, 1);
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk); #1;
                m0_valid = 1'b0; m1_valid = 1'b0;
                #1;
                if (mem_rden | mem_wren) lg.push_back({8'(c), mem_wren, mem_address, mem_wren ? data_in : 16'h0});
                if (mem_rden & mem_wren) viol++;
                if (pw & mem_wren & ((mem_address != pa) | (data_in != pd))) viol++;
                pw = mem_wren; pa = mem_address; pd = data_in;
                if (m0_rsp_valid | m1_rsp_valid) begin
                    lat = c; rid = int'(m1_rsp_valid);
                    rdv = m1_rsp_valid ? m1_rdata : m0_rdata;
                    if (m0_rsp_valid & m1_rsp_valid) viol++;
                    break;
                end
            end
            for (int k = 0; k < 4; k++) begin
                h = k >= 2;
                if (vt[i].we) ex.push_back({8'((k < 2) ? k + 2 : k + 4), 1'b1, {vt[i].a, h}, h ? vt[i].wd[31:16] : vt[i].wd[15:0]});
                else ex.push_back({8'(k + 1), 1'b0, {vt[i].a, h}, 16'h0});
            end
            chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("v%0d_rsp_id", i), rid, vt[i].id);
            chk($sformatf("v%0d_rdata", i), rdv, vt[i].we ? last_rd[vt[i].id] : vt[i].rd);
            if (!vt[i].we) last_rd[vt[i].id] = vt[i].rd;
            chk($sformatf("v%0d_strobe_count", i), lg.size(), 4);
            for (int k = 0; k < 4 && k < lg.size(); k++)
                chk($sformatf("v%0d_strobe%0d", i, k), lg[k], ex[k]);
            chk($sformatf("v%0d_strobe_rules", i), viol, 0);
            @(posedge clk); #2;
            chk($sformatf("v%0d_rsp_pulse", i), {m0_rsp_valid, m1_rsp_valid}, 0);
        end

        m0_we = 1'b0; m0_addr = 19'h10; m1_we = 1'b0; m1_addr = 19'h3;
        m0_valid = 1'b1; m1_valid = 1'b1;
        ng = 0; nr = 0; both = 0; m1seen = 0;
        for (int c = 0; c < 200 && nr < 4; c++) begin
            #1;
            if (m0_ready & m1_ready) both++;
            if (m1_ready) m1seen = 1;
            if (ng < 4 && (m0_ready | m1_ready)) begin gq[ng] = m1_ready; ng++; end
            if (m0_rsp_valid | m1_rsp_valid) begin
                rq[nr] = m1_rsp_valid; rdq[nr] = m1_rsp_valid ? m1_rdata : m0_rdata; nr++;
            end
            @(posedge clk); #1;
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        chk("arb_resp_count", nr, 4);
        chk("arb_both_ready", both, 0);
        chk("arb_m1_seen", m1seen, RR ? 1 : 0);
        for (int k = 0; k < nr; k++) begin
            chk($sformatf("arb_grant%0d", k), gq[k], RR ? ((k % 2) == 1) : 1'b0);
            chk($sformatf("arb_rsp_id%0d", k), rq[k], gq[k]);
            chk($sformatf("arb_rdata%0d", k), rdq[k], gq[k] ? 32'h12345678 : 32'hDEADBEEF);
        end

        @(posedge clk); #1;
        m0_we = 1'b1; m0_addr = 19'h4; m0_wdata = 32'h11112222; m0_valid = 1'b1;
        #1 chk("rst_op_accept", m0_ready, 1);
        @(posedge clk); #1;
        m0_valid = 1'b0;
        @(posedge clk); #1;
        RST = 1'b1;
        #1 chk("rst_op_pulse", mem_wren, 1);
        @(posedge clk); #1;
        RST = 1'b0;
        #1 chk("rst_op_strobes_off", {mem_wren, mem_rden}, 0);
        m1_we = 1'b0; m1_addr = 19'h3; m1_valid = 1'b1;
        #1 chk("rst_op_new_accept", m1_ready, 1);
        lat = -1; n0 = 0; rdv = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            m1_valid = 1'b0;
            #1;
            if (m0_rsp_valid) n0++;
            if (m1_rsp_valid && lat < 0) begin lat = c; rdv = m1_rdata; end
        end
        chk("rst_op_no_rsp", n0, 0);
        chk("rst_op_next_latency", lat, 5);
        chk("rst_op_next_rdata", rdv, 32'h12345678);

        @(posedge clk); #1;
        b_m0_we = 1'b0; b_m0_addr = 19'h10; b_m0_valid = 1'b1;
        rc = -1; nxt = -1; nrd = 0; rdv = '0; cyc = 0;
        for (int c = 0; c <= 30; c++) begin
            #1;
            cyc = c;
            if (c == 0) chk("ws0_first_accept", b_m0_ready, 1);
            if (b_mem_rden) nrd++;
            if (b_m0_rsp_valid && rc < 0) begin rc = c; rdv = b_m0_rdata; end
            if (c > 0 && b_m0_ready) begin nxt = c; break; end
            @(posedge clk); #1;
        end
        b_m0_valid = 1'b0;
        chk("ws0_rsp_cycle", rc, 3);
        chk("ws0_next_accept", nxt, 4);
        chk("ws0_rdata", rdv, 32'hDEADBEEF);
        chk("ws0_rden_cycles", nrd, 2);
        chk("ws0_idle_side", {b_m1_rsp_valid, b_m1_ready, b_mem_wren, b_data_in, b_m1_rdata}, 0);
        if (cyc > 30) chk("ws0_budget", cyc, 30);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
